// File: rtl/simple_axi4_master.sv
// simple_axi4_master: turns each host tcpBus command into one AXI4 INCR burst, one transaction at a time.
// Optional build macro PARTIAL_STRB_EN trims the write strobe on a partial final beat.
module simple_axi4_master #(
    parameter int unsigned MAX_BEATS = 256,
    parameter logic [2:0]  AXSIZE    = 3'b100
) (
    input  logic         clk,
    input  logic         reset,
    output logic         masterAxi_aw_valid,
    input  logic         masterAxi_aw_ready,
    output logic [31:0]  masterAxi_aw_payload_addr,
    output logic [7:0]   masterAxi_aw_payload_len,
    output logic [2:0]   masterAxi_aw_payload_size,
    output logic [1:0]   masterAxi_aw_payload_burst,
    output logic         masterAxi_w_valid,
    input  logic         masterAxi_w_ready,
    output logic [127:0] masterAxi_w_payload_data,
    output logic [15:0]  masterAxi_w_payload_strb,
    output logic         masterAxi_w_payload_last,
    input  logic         masterAxi_b_valid,
    output logic         masterAxi_b_ready,
    input  logic [1:0]   masterAxi_b_payload_resp,
    output logic         masterAxi_ar_valid,
    input  logic         masterAxi_ar_ready,
    output logic [31:0]  masterAxi_ar_payload_addr,
    output logic [7:0]   masterAxi_ar_payload_len,
    output logic [2:0]   masterAxi_ar_payload_size,
    output logic [1:0]   masterAxi_ar_payload_burst,
    input  logic         masterAxi_r_valid,
    output logic         masterAxi_r_ready,
    input  logic [127:0] masterAxi_r_payload_data,
    input  logic [1:0]   masterAxi_r_payload_resp,
    input  logic         masterAxi_r_payload_last,
    input  logic [31:0]  tcpBus_addr,
    input  logic [31:0]  tcpBus_size,
    input  logic         tcpBus_wdata_valid,
    output logic         tcpBus_wdata_ready,
    input  logic [127:0] tcpBus_wdata_payload_fragment,
    input  logic         tcpBus_wdata_payload_last,
    output logic         tcpBus_rdata_valid,
    input  logic         tcpBus_rdata_ready,
    output logic [127:0] tcpBus_rdata_payload_fragment,
    output logic         tcpBus_rdata_payload_last,
    output logic         tcpBus_rsp_valid,
    output logic [1:0]   tcpBus_rsp_payload
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned STRB_W = 16;
    localparam int unsigned BCNT_W = 29;

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          resp_acc_q, resp_acc_d;
    logic                aw_valid_q, aw_valid_d;
    logic                ar_valid_q, ar_valid_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_payload_q, rsp_payload_d;
    logic [BCNT_W-1:0]   beats_c;
    logic [LEN_W-1:0]    len_c;
    logic                w_last_c;
    logic                unused_c;

    // Beat count from byte size, rounded up and clamped; 29 bits cannot overflow.
    assign beats_c  = BCNT_W'(tcpBus_size[31:4]) + BCNT_W'(tcpBus_size[3:0] != 4'd0);
    assign len_c    = (beats_c > BCNT_W'(MAX_BEATS)) ? LEN_W'(MAX_BEATS - 1)
                                                     : LEN_W'(beats_c - BCNT_W'(1));
    assign w_last_c = (cnt_q == len_q);
    assign unused_c = tcpBus_wdata_payload_last;

    assign masterAxi_aw_valid            = aw_valid_q;
    assign masterAxi_aw_payload_addr     = addr_q;
    assign masterAxi_aw_payload_len      = len_q;
    assign masterAxi_aw_payload_size     = AXSIZE;
    assign masterAxi_aw_payload_burst    = 2'b01;
    assign masterAxi_ar_valid            = ar_valid_q;
    assign masterAxi_ar_payload_addr     = addr_q;
    assign masterAxi_ar_payload_len      = len_q;
    assign masterAxi_ar_payload_size     = AXSIZE;
    assign masterAxi_ar_payload_burst    = 2'b01;
    assign masterAxi_w_payload_data      = tcpBus_wdata_payload_fragment;
    assign masterAxi_w_payload_last      = w_last_c;
    assign tcpBus_rdata_payload_fragment = masterAxi_r_payload_data;
    assign tcpBus_rdata_payload_last     = masterAxi_r_payload_last;
    assign tcpBus_rsp_valid              = rsp_valid_q;
    assign tcpBus_rsp_payload            = rsp_payload_q;

`ifdef PARTIAL_STRB_EN
    logic [3:0] size_lo_q, size_lo_d;
    // Only the final beat of a non-multiple-of-16 transfer is trimmed.
    assign masterAxi_w_payload_strb = (w_last_c && (size_lo_q != 4'd0))
                                    ? ((STRB_W'(1) << size_lo_q) - STRB_W'(1))
                                    : {STRB_W{1'b1}};
    always_ff @(posedge clk) begin
        if (reset) size_lo_q <= 4'd0;
        else       size_lo_q <= size_lo_d;
    end
`else
    assign masterAxi_w_payload_strb = {STRB_W{1'b1}};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            resp_acc_q    <= '0;
            aw_valid_q    <= 1'b0;
            ar_valid_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_payload_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            resp_acc_q    <= resp_acc_d;
            aw_valid_q    <= aw_valid_d;
            ar_valid_q    <= ar_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_payload_q <= rsp_payload_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        len_d              = len_q;
        cnt_d              = cnt_q;
        resp_acc_d         = resp_acc_q;
        aw_valid_d         = aw_valid_q;
        ar_valid_d         = ar_valid_q;
        rsp_valid_d        = 1'b0;
        rsp_payload_d      = rsp_payload_q;
`ifdef PARTIAL_STRB_EN
        size_lo_d          = size_lo_q;
`endif
        masterAxi_w_valid  = 1'b0;
        tcpBus_wdata_ready = 1'b0;
        masterAxi_b_ready  = 1'b0;
        masterAxi_r_ready  = 1'b0;
        tcpBus_rdata_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Write wins when both a write beat and a read request are pending.
                if ((tcpBus_size != 32'd0) && (tcpBus_wdata_valid || tcpBus_rdata_ready)) begin
                    addr_d = tcpBus_addr;
                    len_d  = len_c;
                    cnt_d  = '0;
`ifdef PARTIAL_STRB_EN
                    size_lo_d = tcpBus_size[3:0];
`endif
                    if (tcpBus_wdata_valid) begin
                        aw_valid_d = 1'b1;
                        state_d    = AW;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = AR;
                    end
                end
            end
            AW: begin
                if (masterAxi_aw_ready) begin
                    aw_valid_d = 1'b0;
                    state_d    = W;
                end
            end
            W: begin
                masterAxi_w_valid  = tcpBus_wdata_valid;
                tcpBus_wdata_ready = masterAxi_w_ready;
                if (tcpBus_wdata_valid && masterAxi_w_ready) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (w_last_c) state_d = B;
                end
            end
            B: begin
                masterAxi_b_ready = 1'b1;
                if (masterAxi_b_valid) begin
                    rsp_valid_d   = 1'b1;
                    rsp_payload_d = masterAxi_b_payload_resp;
                    state_d       = DONE;
                end
            end
            AR: begin
                if (masterAxi_ar_ready) begin
                    ar_valid_d = 1'b0;
                    resp_acc_d = '0;
                    state_d    = R;
                end
            end
            R: begin
                tcpBus_rdata_valid = masterAxi_r_valid;
                masterAxi_r_ready  = tcpBus_rdata_ready;
                if (masterAxi_r_valid && tcpBus_rdata_ready) begin
                    resp_acc_d = resp_acc_q | masterAxi_r_payload_resp;
                    if (masterAxi_r_payload_last) begin
                        rsp_valid_d   = 1'b1;
                        rsp_payload_d = resp_acc_q | masterAxi_r_payload_resp;
                        state_d       = DONE;
                    end
                end
            end
            DONE: begin
                // Wait for the host to drop its request so a held level never re-triggers.
                if (!tcpBus_wdata_valid && !tcpBus_rdata_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_simple_axi4_master.sv
// tb_simple_axi4_master: scoreboard bench with a small AXI slave model driven from scenario tasks.
module tb_simple_axi4_master;
    logic         clk = 1'b0;
    logic         reset;
    logic         masterAxi_aw_valid, masterAxi_aw_ready;
    logic [31:0]  masterAxi_aw_payload_addr;
    logic [7:0]   masterAxi_aw_payload_len;
    logic [2:0]   masterAxi_aw_payload_size;
    logic [1:0]   masterAxi_aw_payload_burst;
    logic         masterAxi_w_valid, masterAxi_w_ready;
    logic [127:0] masterAxi_w_payload_data;
    logic [15:0]  masterAxi_w_payload_strb;
    logic         masterAxi_w_payload_last;
    logic         masterAxi_b_valid, masterAxi_b_ready;
    logic [1:0]   masterAxi_b_payload_resp;
    logic         masterAxi_ar_valid, masterAxi_ar_ready;
    logic [31:0]  masterAxi_ar_payload_addr;
    logic [7:0]   masterAxi_ar_payload_len;
    logic [2:0]   masterAxi_ar_payload_size;
    logic [1:0]   masterAxi_ar_payload_burst;
    logic         masterAxi_r_valid, masterAxi_r_ready;
    logic [127:0] masterAxi_r_payload_data;
    logic [1:0]   masterAxi_r_payload_resp;
    logic         masterAxi_r_payload_last;
    logic [31:0]  tcpBus_addr, tcpBus_size;
    logic         tcpBus_wdata_valid, tcpBus_wdata_ready;
    logic [127:0] tcpBus_wdata_payload_fragment;
    logic         tcpBus_wdata_payload_last;
    logic         tcpBus_rdata_valid, tcpBus_rdata_ready;
    logic [127:0] tcpBus_rdata_payload_fragment;
    logic         tcpBus_rdata_payload_last;
    logic         tcpBus_rsp_valid;
    logic [1:0]   tcpBus_rsp_payload;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [15:0]  strb;
    } wexp_t;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } rexp_t;

    wexp_t       w_q[$];
    rexp_t       r_q[$];
    logic [1:0]  rsp_q[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    simple_axi4_master dut (
        .clk(clk), .reset(reset),
        .masterAxi_aw_valid(masterAxi_aw_valid), .masterAxi_aw_ready(masterAxi_aw_ready),
        .masterAxi_aw_payload_addr(masterAxi_aw_payload_addr), .masterAxi_aw_payload_len(masterAxi_aw_payload_len),
        .masterAxi_aw_payload_size(masterAxi_aw_payload_size), .masterAxi_aw_payload_burst(masterAxi_aw_payload_burst),
        .masterAxi_w_valid(masterAxi_w_valid), .masterAxi_w_ready(masterAxi_w_ready),
        .masterAxi_w_payload_data(masterAxi_w_payload_data), .masterAxi_w_payload_strb(masterAxi_w_payload_strb),
        .masterAxi_w_payload_last(masterAxi_w_payload_last),
        .masterAxi_b_valid(masterAxi_b_valid), .masterAxi_b_ready(masterAxi_b_ready),
        .masterAxi_b_payload_resp(masterAxi_b_payload_resp),
        .masterAxi_ar_valid(masterAxi_ar_valid), .masterAxi_ar_ready(masterAxi_ar_ready),
        .masterAxi_ar_payload_addr(masterAxi_ar_payload_addr), .masterAxi_ar_payload_len(masterAxi_ar_payload_len),
        .masterAxi_ar_payload_size(masterAxi_ar_payload_size), .masterAxi_ar_payload_burst(masterAxi_ar_payload_burst),
        .masterAxi_r_valid(masterAxi_r_valid), .masterAxi_r_ready(masterAxi_r_ready),
        .masterAxi_r_payload_data(masterAxi_r_payload_data), .masterAxi_r_payload_resp(masterAxi_r_payload_resp),
        .masterAxi_r_payload_last(masterAxi_r_payload_last),
        .tcpBus_addr(tcpBus_addr), .tcpBus_size(tcpBus_size),
        .tcpBus_wdata_valid(tcpBus_wdata_valid), .tcpBus_wdata_ready(tcpBus_wdata_ready),
        .tcpBus_wdata_payload_fragment(tcpBus_wdata_payload_fragment),
        .tcpBus_wdata_payload_last(tcpBus_wdata_payload_last),
        .tcpBus_rdata_valid(tcpBus_rdata_valid), .tcpBus_rdata_ready(tcpBus_rdata_ready),
        .tcpBus_rdata_payload_fragment(tcpBus_rdata_payload_fragment),
        .tcpBus_rdata_payload_last(tcpBus_rdata_payload_last),
        .tcpBus_rsp_valid(tcpBus_rsp_valid), .tcpBus_rsp_payload(tcpBus_rsp_payload)
    );

    function automatic logic [127:0] beat_data(input logic [31:0] seed, input int i);
        return {seed, 32'(i), 56'h0, 8'hA5};
    endfunction

    function automatic logic [15:0] exp_strb(input logic [31:0] size, input logic last);
        logic [15:0] s;
        s = 16'hFFFF;
`ifdef PARTIAL_STRB_EN
        if (last && size[3:0] != 4'd0) s = (16'd1 << size[3:0]) - 16'd1;
`endif
        return s;
    endfunction

    task automatic idle_inputs();
        masterAxi_aw_ready = 1'b0; masterAxi_w_ready = 1'b0; masterAxi_b_valid = 1'b0;
        masterAxi_b_payload_resp = 2'b00; masterAxi_ar_ready = 1'b0; masterAxi_r_valid = 1'b0;
        masterAxi_r_payload_data = '0; masterAxi_r_payload_resp = 2'b00; masterAxi_r_payload_last = 1'b0;
        tcpBus_wdata_valid = 1'b0; tcpBus_wdata_payload_fragment = '0; tcpBus_wdata_payload_last = 1'b0;
        tcpBus_rdata_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        tcpBus_addr = 32'h0; tcpBus_size = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({masterAxi_aw_valid, masterAxi_w_valid, masterAxi_ar_valid, tcpBus_rdata_valid, tcpBus_rsp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b want 00000", {masterAxi_aw_valid, masterAxi_w_valid,
                     masterAxi_ar_valid, tcpBus_rdata_valid, tcpBus_rsp_valid});
        end
        checks++;
        if ({masterAxi_b_ready, masterAxi_r_ready, tcpBus_wdata_ready, tcpBus_rsp_payload} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ready_rsp: got %b want 00000", {masterAxi_b_ready, masterAxi_r_ready,
                     tcpBus_wdata_ready, tcpBus_rsp_payload});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Write scenario: host streams nbeats, slave accepts AW late and optionally toggles w_ready.
    task automatic run_write(input string name, input logic [31:0] addr, input logic [31:0] size,
                             input int nbeats, input logic [7:0] exp_len, input logic [1:0] bresp,
                             input bit toggle);
        wexp_t e;
        logic [1:0] er;
        int idx = 0, aw_hs = 0, w_hs = 0, rsp_n = 0, cyc = 0, tail = 0;
        bit b_done = 0, early_w = 0;
        for (int i = 0; i < nbeats; i++) begin
            e.data = beat_data(addr, i);
            e.last = (i == nbeats - 1);
            e.strb = exp_strb(size, e.last);
            w_q.push_back(e);
        end
        rsp_q.push_back(bresp);
        tcpBus_addr = addr; tcpBus_size = size;
        while (tail < 4 && cyc < 3000) begin
            tcpBus_wdata_valid            = (idx < nbeats);
            tcpBus_wdata_payload_fragment = beat_data(addr, idx);
            tcpBus_wdata_payload_last     = 1'b0;
            masterAxi_aw_ready            = (cyc >= 3);
            masterAxi_w_ready             = toggle ? (cyc % 2 == 1) : 1'b1;
            masterAxi_b_valid             = (w_hs == nbeats) && !b_done;
            masterAxi_b_payload_resp      = bresp;
            #1;
            if (masterAxi_w_valid && aw_hs == 0) early_w = 1;
            if (masterAxi_aw_valid && masterAxi_aw_ready) begin
                aw_hs++;
                checks++;
                if ({masterAxi_aw_payload_addr, masterAxi_aw_payload_len, masterAxi_aw_payload_size,
                     masterAxi_aw_payload_burst} !== {addr, exp_len, 3'b100, 2'b01}) begin
                    errors++;
                    $display("FAIL %s aw_payload: got %h/%0d/%0d/%0d want %h/%0d/4/1", name,
                             masterAxi_aw_payload_addr, masterAxi_aw_payload_len, masterAxi_aw_payload_size,
                             masterAxi_aw_payload_burst, addr, exp_len);
                end
            end
            if (masterAxi_w_valid && masterAxi_w_ready) begin
                w_hs++; idx++;
                checks++;
                if (w_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s w_extra_beat: got beat %0d want none", name, w_hs);
                end else begin
                    e = w_q.pop_front();
                    if ({masterAxi_w_payload_data, masterAxi_w_payload_last, masterAxi_w_payload_strb} !== e) begin
                        errors++;
                        $display("FAIL %s w_beat%0d: got %h last=%b strb=%h want %h last=%b strb=%h", name,
                                 w_hs - 1, masterAxi_w_payload_data, masterAxi_w_payload_last,
                                 masterAxi_w_payload_strb, e.data, e.last, e.strb);
                    end
                end
            end
            if (masterAxi_b_valid && masterAxi_b_ready) b_done = 1;
            if (tcpBus_rsp_valid) begin
                rsp_n++;
                checks++;
                er = (rsp_q.size() != 0) ? rsp_q.pop_front() : 2'bxx;
                if (tcpBus_rsp_payload !== er) begin
                    errors++;
                    $display("FAIL %s rsp_payload: got %b want %b", name, tcpBus_rsp_payload, er);
                end
            end
            if (rsp_n > 0) tail++;
            cyc++;
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if ({aw_hs, w_hs, rsp_n, 32'(early_w)} !== {32'd1, 32'(nbeats), 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL %s counts: got aw=%0d w=%0d rsp=%0d early_w=%0d want aw=1 w=%0d rsp=1 early_w=0",
                     name, aw_hs, w_hs, rsp_n, early_w, nbeats);
        end
        w_q.delete(); rsp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Read scenario: slave returns nbeats with resp first_resp on beat 0 and last_resp on the final beat.
    task automatic run_read(input string name, input logic [31:0] addr, input logic [31:0] size,
                            input int nbeats, input logic [7:0] exp_len, input logic [1:0] first_resp,
                            input logic [1:0] last_resp, input int hold);
        rexp_t e;
        logic [1:0] er, acc;
        int ridx = 0, ar_hs = 0, r_hs = 0, rsp_n = 0, cyc = 0, tail = 0;
        acc = 2'b00;
        for (int i = 0; i < nbeats; i++) begin
            e.data = beat_data(~addr, i);
            e.last = (i == nbeats - 1);
            r_q.push_back(e);
            acc |= (i == nbeats - 1) ? last_resp : ((i == 0) ? first_resp : 2'b00);
        end
        rsp_q.push_back(acc);
        tcpBus_addr = addr; tcpBus_size = size;
        while (tail < hold && cyc < 3000) begin
            tcpBus_rdata_ready       = 1'b1;
            masterAxi_ar_ready       = (cyc >= 2);
            masterAxi_r_valid        = (ar_hs > 0) && (ridx < nbeats);
            masterAxi_r_payload_data = beat_data(~addr, ridx);
            masterAxi_r_payload_last = (ridx == nbeats - 1);
            masterAxi_r_payload_resp = (ridx == nbeats - 1) ? last_resp : ((ridx == 0) ? first_resp : 2'b00);
            #1;
            if (masterAxi_ar_valid && masterAxi_ar_ready) begin
                ar_hs++;
                checks++;
                if ({masterAxi_ar_payload_addr, masterAxi_ar_payload_len, masterAxi_ar_payload_size,
                     masterAxi_ar_payload_burst} !== {addr, exp_len, 3'b100, 2'b01}) begin
                    errors++;
                    $display("FAIL %s ar_payload: got %h/%0d/%0d/%0d want %h/%0d/4/1", name,
                             masterAxi_ar_payload_addr, masterAxi_ar_payload_len, masterAxi_ar_payload_size,
                             masterAxi_ar_payload_burst, addr, exp_len);
                end
            end
            if (masterAxi_r_valid && masterAxi_r_ready) begin
                r_hs++; ridx++;
                checks++;
                if (r_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s r_extra_beat: got beat %0d want none", name, r_hs);
                end else begin
                    e = r_q.pop_front();
                    if ({tcpBus_rdata_valid, tcpBus_rdata_payload_fragment, tcpBus_rdata_payload_last} !== {1'b1, e}) begin
                        errors++;
                        $display("FAIL %s r_beat%0d: got v=%b %h last=%b want v=1 %h last=%b", name, r_hs - 1,
                                 tcpBus_rdata_valid, tcpBus_rdata_payload_fragment, tcpBus_rdata_payload_last,
                                 e.data, e.last);
                    end
                end
            end
            if (tcpBus_rsp_valid) begin
                rsp_n++;
                checks++;
                er = (rsp_q.size() != 0) ? rsp_q.pop_front() : 2'bxx;
                if (tcpBus_rsp_payload !== er) begin
                    errors++;
                    $display("FAIL %s rsp_payload: got %b want %b", name, tcpBus_rsp_payload, er);
                end
            end
            if (rsp_n > 0) tail++;
            cyc++;
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if ({ar_hs, r_hs, rsp_n} !== {32'd1, 32'(nbeats), 32'd1}) begin
            errors++;
            $display("FAIL %s counts: got ar=%0d r=%0d rsp=%0d want ar=1 r=%0d rsp=1",
                     name, ar_hs, r_hs, rsp_n, nbeats);
        end
        r_q.delete(); rsp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        run_write("single_write", 32'h0000_1000, 32'd16, 1, 8'd0, 2'b00, 1'b0);
    endtask

    task automatic test_burst_read();
        run_read("burst_read", 32'h0000_2000, 32'd64, 4, 8'd3, 2'b00, 2'b00, 12);
    endtask

    task automatic test_backpressure();
        run_write("backpressure", 32'h0000_3000, 32'd48, 3, 8'd2, 2'b00, 1'b1);
    endtask

    task automatic test_error_resp();
        run_read("read_err", 32'h0000_4000, 32'd32, 2, 8'd1, 2'b00, 2'b10, 3);
        run_read("read_err_or", 32'h0000_4100, 32'd33, 3, 8'd2, 2'b01, 2'b10, 3);
        run_write("write_err", 32'h0000_5000, 32'd32, 2, 8'd1, 2'b11, 1'b0);
    endtask

    task automatic test_zero_size();
        int hits = 0;
        tcpBus_addr = 32'h0000_6000; tcpBus_size = 32'd0;
        tcpBus_wdata_valid = 1'b1; tcpBus_rdata_ready = 1'b1;
        masterAxi_aw_ready = 1'b1; masterAxi_ar_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (masterAxi_aw_valid || masterAxi_ar_valid || tcpBus_rsp_valid) hits++;
        end
        idle_inputs();
        checks++;
        if (hits !== 0) begin
            errors++;
            $display("FAIL zero_size: got %0d active cycles want 0", hits);
        end
        @(negedge clk);
    endtask

    task automatic test_clamp_and_strb();
        run_write("clamp", 32'h0001_0000, 32'd8192, 256, 8'd255, 2'b00, 1'b0);
        run_write("partial_strb", 32'h0000_7000, 32'd20, 2, 8'd1, 2'b01, 1'b0);
        run_read("read_round_up", 32'h0000_7100, 32'd17, 2, 8'd1, 2'b00, 2'b00, 3);
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        tcpBus_addr = 32'h0000_8000; tcpBus_size = 32'd64; tcpBus_rdata_ready = 1'b1;
        while (!masterAxi_ar_valid && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        checks++;
        if (masterAxi_ar_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_start: got ar_valid=%b want 1", masterAxi_ar_valid);
        end
        reset = 1'b1; tcpBus_rdata_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({masterAxi_ar_valid, tcpBus_rsp_valid, tcpBus_rsp_payload} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset: got ar_valid=%b rsp=%b/%b want 0/0/00", masterAxi_ar_valid,
                     tcpBus_rsp_valid, tcpBus_rsp_payload);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_read();
        test_backpressure();
        test_error_resp();
        test_zero_size();
        test_mid_reset();
        test_clamp_and_strb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
